// File: rtl/spi_stream_dma.sv
// spi_stream_dma: single-channel AHB-Lite master that drains the SPI stream RX FIFO
// into an incrementing memory buffer, one read/write word pair at a time.
module spi_stream_dma (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cfg_src_addr,
  input  logic [31:0] cfg_dst_addr,
  input  logic [15:0] cfg_count,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic        status_clr,
  input  logic        dreq,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        irq,
  output logic [15:0] remaining,
  output logic [31:0] ahblm_haddr,
  output logic [1:0]  ahblm_htrans,
  output logic        ahblm_hwrite,
  output logic [2:0]  ahblm_hsize,
  output logic [31:0] ahblm_hwdata,
  input  logic        ahblm_hready,
  input  logic        ahblm_hresp,
  input  logic [31:0] ahblm_hrdata
);

  // state | meaning
  // IDLE  | no run in progress
  // WAIT  | run active, waiting for dreq
  // RD_A  | FIFO read address phase
  // RD_D  | FIFO read data phase
  // WR_A  | memory write address phase
  // WR_D  | memory write data phase
  typedef enum logic [2:0] {IDLE, WAIT, RD_A, RD_D, WR_A, WR_D} state_t;

  state_t      state, state_nxt;
  logic [31:0] dst;
  logic [15:0] cnt;
  logic [31:0] data;
  logic        abort_pend;
  logic        load, rd_done, word_done, done_set, err_set;
  logic        stop_req;

  assign stop_req = abort_pend | cfg_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    rd_done      = 1'b0;
    word_done    = 1'b0;
    done_set     = 1'b0;
    err_set      = 1'b0;
    ahblm_htrans = 2'b00;
    ahblm_haddr  = 32'h0;
    ahblm_hwrite = 1'b0;
    ahblm_hwdata = 32'h0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          load = 1'b1;
          if (cfg_count == 16'd0) done_set  = 1'b1;
          else                    state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (stop_req)  state_nxt = IDLE;
        else if (dreq) state_nxt = RD_A;
      end
      RD_A: begin
        ahblm_htrans = 2'b10;
        ahblm_haddr  = cfg_src_addr;
        if (ahblm_hready) state_nxt = RD_D;
      end
      RD_D: begin
        if (ahblm_hresp) begin
          err_set = 1'b1;
          if (ahblm_hready) state_nxt = IDLE;
        end else if (ahblm_hready) begin
          rd_done   = 1'b1;
          // an abort seen by the end of the read drops the word rather than writing it
          state_nxt = stop_req ? IDLE : WR_A;
        end
      end
      WR_A: begin
        ahblm_htrans = 2'b10;
        ahblm_haddr  = dst;
        ahblm_hwrite = 1'b1;
        if (ahblm_hready) state_nxt = WR_D;
      end
      WR_D: begin
        ahblm_hwdata = data;
        if (ahblm_hresp) begin
          err_set = 1'b1;
          if (ahblm_hready) state_nxt = IDLE;
        end else if (ahblm_hready) begin
          word_done = 1'b1;
          if (cnt == 16'd1) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else if (stop_req) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst        <= 32'h0;
      cnt        <= 16'h0;
      data       <= 32'h0;
      abort_pend <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (load) begin
        dst <= cfg_dst_addr & 32'hFFFF_FFFC;
        cnt <= cfg_count;
      end else if (word_done) begin
        dst <= dst + 32'd4;
        cnt <= cnt - 16'd1;
      end
      if (rd_done) data <= ahblm_hrdata;
      if (state_nxt == IDLE || err_set)
        abort_pend <= 1'b0;
      else if (cfg_abort && state != IDLE && state != WAIT)
        abort_pend <= 1'b1;
      if (done_set)        done <= 1'b1;
      else if (status_clr) done <= 1'b0;
      if (err_set)         err  <= 1'b1;
      else if (status_clr) err  <= 1'b0;
    end
  end

  assign busy        = (state != IDLE);
  assign irq         = done | err;
  assign remaining   = cnt;
  assign ahblm_hsize = 3'b010;

endmodule
